hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Hazard stall unit for the 5-stage pipeline. It generates the stall and bubble controls that data forwarding cannot resolve.
- Load-use hazard: a load in EX whose destination is read by the instruction in ID. The unit inserts one ID/EX bubble and holds PC and IF/ID.
- Data-memory wait: a MEM-stage access not yet acknowledged. The unit freezes the whole pipeline until acknowledge, or until timeout.
- Sits beside the forwarding control, which picks up the stalled operand from MEM/WB one cycle later.

Parameters:
- MAX_WAIT, 15, maximum consecutive dmem wait cycles before the timeout error (legal range 1..255).
- WAIT_CNT_W, 8, width of the wait counter; must satisfy 2^WAIT_CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_instr_opcode_ip  input  7  opcode of the instruction in ID.
- id_rs1_ip  input  5  rs1 field of the instruction in ID.
- id_rs2_ip  input  5  rs2 field of the instruction in ID.
- ID_EX_dest_ip  input  5  destination register of the instruction in EX.
- ID_EX_wb_mux_ip  input  write_back_mux_selector  writeback source of the instruction in EX.
- dmem_req_ip  input  1  MEM stage is issuing a data-memory access this cycle.
- dmem_ready_ip  input  1  data memory acknowledges the current access.
- pc_stall_op  output  1  hold PC.
- if_id_stall_op  output  1  hold the IF/ID register.
- id_ex_bubble_op  output  1  load NOP (NO_WRITEBACK) into ID/EX.
- id_ex_stall_op  output  1  hold the ID/EX register.
- ex_mem_stall_op  output  1  hold EX/MEM; MEM/WB receives a bubble.
- mem_timeout_op  output  1  sticky memory-timeout error flag.

Behaviour:
- Reset: state=IDLE, wait_cnt=0, all outputs 0. Reset wins in any state, including ERROR and MEM_WAIT mid-wait.
- Operand use is decoded from id_instr_opcode_ip:
  - OP, STORE, BRANCH: use rs1 and rs2.
  - OPIMM, LOAD, JALR: use rs1 only.
  - LUI, AUIPC, JAL and any other opcode: no sources.
- A source equal to x0 never causes a hazard.
- load_use = (ID_EX_wb_mux_ip == LOAD_WRITEBACK) && ID_EX_dest_ip != 0 && the dest matches a used source.
- mem_wait = dmem_req_ip && !dmem_ready_ip.
- FSM states: IDLE, MEM_WAIT, ERROR. All outputs are combinational from state and inputs (Mealy), so a stall asserts in the same cycle its condition appears.
- IDLE:
  - If mem_wait: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall; id_ex_bubble=0; next state MEM_WAIT; wait_cnt<=1.
  - Else if load_use: assert pc_stall, if_id_stall, id_ex_bubble for exactly that cycle. The next cycle EX holds the bubble, so the hazard clears by itself. Stay in IDLE.
  - Else: all outputs 0.
- MEM_WAIT:
  - If dmem_ready_ip=1: all stalls 0 this cycle so the pipeline advances; next state IDLE; wait_cnt<=0.
  - Else if wait_cnt==MAX_WAIT: full stall held; next state ERROR.
  - Else: full stall; wait_cnt<=wait_cnt+1.
  - load_use is ignored while in MEM_WAIT; the pipeline is frozen and the check resumes in IDLE.
- ERROR: all four stalls 1, id_ex_bubble 0, mem_timeout_op 1. Only reset exits.
- Simultaneous mem_wait and load_use in IDLE: mem_wait has priority; no bubble in that cycle. The load-use bubble is issued in the first IDLE cycle after ready.
- The counter never wraps. It is bounded by MAX_WAIT.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs lu_stall_cnt_op[31:0] and mem_stall_cnt_op[31:0].
  - lu_stall_cnt_op increments on every cycle with id_ex_bubble_op=1.
  - mem_stall_cnt_op increments on every cycle with ex_mem_stall_op=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- CORE_PKG holds:
  - opcode constants, including OPCODE_OP and OPCODE_OPIMM;
  - the write_back_mux_selector enum, including NO_WRITEBACK and LOAD_WRITEBACK;
  - a new enum hazard_state_e {IDLE, MEM_WAIT, ERROR}.
- One sub-module: src_use_decode. Combinational; maps opcode to uses_rs1/uses_rs2. It is to be reused by the forwarding control.

Test Plan:
- LW x5 in EX, ID=ADD x6,x5,x7 (OPCODE_OP), no dmem req -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then all 0.
- LW x0 in EX, ID=ADDI x1,x0,4 -> no stall. Same with ID=LUI x5 after LW x5 -> no stall.
- dmem_req=1, ready=0 for 3 cycles, then 1 -> full stall for exactly 3 cycles, 0 in the ready cycle, state IDLE, mem_timeout_op=0.
- MAX_WAIT=15, ready held 0 -> 16 stall cycles, then ERROR with mem_timeout_op=1 held. Assert reset for 1 cycle -> all outputs 0.
- mem_wait and load-use (LW x3 in EX, SW with rs2=x3 in ID) in the same cycle -> no bubble during the wait; bubble asserted in the single cycle after ready.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus a 3-cycle mem wait -> lu_stall_cnt_op=2, mem_stall_cnt_op=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline definitions: opcodes, writeback selector, hazard FSM states
// and the bundle of stall controls driven by the hazard stall unit.
package core_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        NO_WRITEBACK,
        ALU_WRITEBACK,
        LOAD_WRITEBACK,
        PC_WRITEBACK
    } write_back_mux_selector;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        ERROR
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_bubble;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_timeout;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_NONE = '0;

    localparam hazard_ctrl_t CTRL_LOAD_USE = '{
        pc_stall:     1'b1,
        if_id_stall:  1'b1,
        id_ex_bubble: 1'b1,
        default:      1'b0
    };

    // Whole-pipeline freeze; the timeout flag rides along only in the error state.
    function automatic hazard_ctrl_t ctrl_freeze(input logic timeout);
        hazard_ctrl_t c;
        c              = CTRL_NONE;
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.id_ex_stall  = 1'b1;
        c.ex_mem_stall = 1'b1;
        c.mem_timeout  = timeout;
        return c;
    endfunction

endpackage

// File: rtl/src_use_decode.sv
// Maps an instruction opcode to which source register fields it actually reads.
// Shared with the forwarding control so both agree on operand usage.
module src_use_decode
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: begin
                uses_rs1 = 1'b1;
            end
            // Immediate-only and jump forms carry garbage in the rs fields.
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubble and data-memory wait freeze for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle counters.
module hazard_stall_unit
    import core_pkg::*;
#(
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned WAIT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            id_instr_opcode_ip,
    input  logic [4:0]            id_rs1_ip,
    input  logic [4:0]            id_rs2_ip,
    input  logic [4:0]            ID_EX_dest_ip,
    input  write_back_mux_selector ID_EX_wb_mux_ip,
    input  logic                  dmem_req_ip,
    input  logic                  dmem_ready_ip,
    output logic                  pc_stall_op,
    output logic                  if_id_stall_op,
    output logic                  id_ex_bubble_op,
    output logic                  id_ex_stall_op,
    output logic                  ex_mem_stall_op,
    output logic                  mem_timeout_op,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           lu_stall_cnt_op,
    output logic [31:0]           mem_stall_cnt_op,
`endif
    output hazard_state_e         state_dbg
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    hazard_state_e         state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  load_use;
    logic                  mem_wait;
    hazard_ctrl_t          ctrl;

    src_use_decode u_src_use_decode (
        .opcode   (id_instr_opcode_ip),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // dest != 0 also filters out x0 sources, since a hit requires equality.
    assign rs1_hit  = uses_rs1 && (id_rs1_ip == ID_EX_dest_ip);
    assign rs2_hit  = uses_rs2 && (id_rs2_ip == ID_EX_dest_ip);
    assign load_use = (ID_EX_wb_mux_ip == LOAD_WRITEBACK) && (ID_EX_dest_ip != 5'd0)
                      && (rs1_hit || rs2_hit);

    // dmem handshake: an access is pending while req is high; it completes in the
    // cycle ready is high. Any req-without-ready cycle must freeze the pipeline.
    assign mem_wait = dmem_req_ip && !dmem_ready_ip;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready_ip) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Mealy outputs so a stall takes effect in the cycle its cause appears.
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            IDLE: begin
                if (mem_wait) begin
                    ctrl = ctrl_freeze(1'b0);
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready_ip) begin
                    ctrl = ctrl_freeze(1'b0);
                end
            end
            ERROR: begin
                ctrl = ctrl_freeze(1'b1);
            end
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

    assign pc_stall_op     = ctrl.pc_stall;
    assign if_id_stall_op  = ctrl.if_id_stall;
    assign id_ex_bubble_op = ctrl.id_ex_bubble;
    assign id_ex_stall_op  = ctrl.id_ex_stall;
    assign ex_mem_stall_op = ctrl.ex_mem_stall;
    assign mem_timeout_op  = ctrl.mem_timeout;
    assign state_dbg       = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt;
    logic [31:0] mem_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt  <= '0;
            mem_cnt <= '0;
        end else begin
            if (ctrl.id_ex_bubble && (lu_cnt != 32'hFFFF_FFFF)) begin
                lu_cnt <= lu_cnt + 32'd1;
            end
            if (ctrl.ex_mem_stall && (mem_cnt != 32'hFFFF_FFFF)) begin
                mem_cnt <= mem_cnt + 32'd1;
            end
        end
    end

    assign lu_stall_cnt_op  = lu_cnt;
    assign mem_stall_cnt_op = mem_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_stall_unit;
    import core_pkg::*;

    localparam int MAX_WAIT = 15;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [6:0]             id_instr_opcode_ip;
    logic [4:0]             id_rs1_ip;
    logic [4:0]             id_rs2_ip;
    logic [4:0]             ID_EX_dest_ip;
    write_back_mux_selector ID_EX_wb_mux_ip;
    logic                   dmem_req_ip;
    logic                   dmem_ready_ip;
    logic                   pc_stall_op;
    logic                   if_id_stall_op;
    logic                   id_ex_bubble_op;
    logic                   id_ex_stall_op;
    logic                   ex_mem_stall_op;
    logic                   mem_timeout_op;
    hazard_state_e          state_dbg;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]            lu_stall_cnt_op;
    logic [31:0]            mem_stall_cnt_op;
    logic [31:0]            m_lu_cnt = '0;
    logic [31:0]            m_mem_cnt = '0;
`endif

    hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .id_instr_opcode_ip (id_instr_opcode_ip),
        .id_rs1_ip          (id_rs1_ip),
        .id_rs2_ip          (id_rs2_ip),
        .ID_EX_dest_ip      (ID_EX_dest_ip),
        .ID_EX_wb_mux_ip    (ID_EX_wb_mux_ip),
        .dmem_req_ip        (dmem_req_ip),
        .dmem_ready_ip      (dmem_ready_ip),
        .pc_stall_op        (pc_stall_op),
        .if_id_stall_op     (if_id_stall_op),
        .id_ex_bubble_op    (id_ex_bubble_op),
        .id_ex_stall_op     (id_ex_stall_op),
        .ex_mem_stall_op    (ex_mem_stall_op),
        .mem_timeout_op     (mem_timeout_op),
`ifdef HAZARD_PERF_CNT_EN
        .lu_stall_cnt_op    (lu_stall_cnt_op),
        .mem_stall_cnt_op   (mem_stall_cnt_op),
`endif
        .state_dbg          (state_dbg)
    );

    always #5 clk = ~clk;

    // Output vector order: {pc, if_id, bubble, id_ex, ex_mem, timeout}
    localparam logic [5:0] E_NONE   = 6'b000000;
    localparam logic [5:0] E_BUBBLE = 6'b111000;
    localparam logic [5:0] E_FREEZE = 6'b110110;
    localparam logic [5:0] E_ERROR  = 6'b110111;

    logic [6:0] exp_q[$];  // {reset_this_cycle, expected outputs}
    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: length of the current unacknowledged-access run, and the error latch.
    int streak = 0;
    bit err    = 1'b0;

    logic [6:0] two_src_ops[3] = '{OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    logic [6:0] one_src_ops[3] = '{OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR};
    logic [6:0] opc_tab[9] = '{OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH, OPCODE_OPIMM,
                               OPCODE_LOAD, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL};

    function automatic logic [1:0] src_use(input logic [6:0] opc);
        foreach (two_src_ops[i]) if (opc == two_src_ops[i]) return 2'b11;
        foreach (one_src_ops[i]) if (opc == one_src_ops[i]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [5:0] dut_vec();
        return {pc_stall_op, if_id_stall_op, id_ex_bubble_op, id_ex_stall_op,
                ex_mem_stall_op, mem_timeout_op};
    endfunction

    task automatic drive(input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input write_back_mux_selector wb,
                         input logic rq, input logic rd, input logic rs);
        logic [1:0] u;
        logic       lu;
        logic       pending;
        logic [5:0] e;
        @(posedge clk);
        #1;
        id_instr_opcode_ip = opc;
        id_rs1_ip          = r1;
        id_rs2_ip          = r2;
        ID_EX_dest_ip      = d;
        ID_EX_wb_mux_ip    = wb;
        dmem_req_ip        = rq;
        dmem_ready_ip      = rd;
        reset              = rs;
        u       = src_use(opc);
        lu      = (wb == LOAD_WRITEBACK) && (d != 5'd0) &&
                  ((u[1] && r1 == d) || (u[0] && r2 == d));
        pending = rq && !rd;
        if (err)              e = E_ERROR;
        else if (streak > 0)  e = rd ? E_NONE : E_FREEZE;
        else if (pending)     e = E_FREEZE;
        else if (lu)          e = E_BUBBLE;
        else                  e = E_NONE;
        exp_q.push_back({rs, e});
        if (rs) begin
            streak = 0;
            err    = 1'b0;
        end else if (!err) begin
            if (streak > 0) begin
                if (rd) streak = 0;
                else begin
                    streak++;
                    if (streak > MAX_WAIT) err = 1'b1;
                end
            end else if (pending) begin
                streak = 1;
            end
        end
    endtask

    task automatic idle(input logic rs);
        drive(7'h00, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 1'b0, 1'b0, rs);
    endtask

    task automatic check_lit(input string name, input logic [5:0] want);
        @(negedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, dut_vec(), want);
        end
    endtask

    task automatic check_state(input string name, input hazard_state_e want);
        n_cmp++;
        if (state_dbg !== want) begin
            n_fail++;
            $display("FAIL %s: state got %0d want %0d", name, state_dbg, want);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [6:0] ent;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            n_cmp++;
            if (dut_vec() !== ent[5:0]) begin
                n_fail++;
                $display("FAIL model_cmp @%0t: got %b want %b", $time, dut_vec(), ent[5:0]);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_cmp++;
            if (lu_stall_cnt_op !== m_lu_cnt || mem_stall_cnt_op !== m_mem_cnt) begin
                n_fail++;
                $display("FAIL perf_cmp @%0t: got lu=%0d mem=%0d want lu=%0d mem=%0d",
                         $time, lu_stall_cnt_op, mem_stall_cnt_op, m_lu_cnt, m_mem_cnt);
            end
            if (ent[6]) begin
                m_lu_cnt  = '0;
                m_mem_cnt = '0;
            end else begin
                if (ent[3] && m_lu_cnt != 32'hFFFF_FFFF)  m_lu_cnt++;
                if (ent[1] && m_mem_cnt != 32'hFFFF_FFFF) m_mem_cnt++;
            end
`endif
        end
    end

    initial begin
        int rdy_pct;
        logic [6:0] opc;
        int idx;
        reset = 1'b1;
        id_instr_opcode_ip = '0;
        id_rs1_ip = '0;
        id_rs2_ip = '0;
        ID_EX_dest_ip = '0;
        ID_EX_wb_mux_ip = NO_WRITEBACK;
        dmem_req_ip = 1'b0;
        dmem_ready_ip = 1'b0;

        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        check_lit("reset_idle", E_NONE);
        check_state("reset_state", IDLE);

        // LW x5 in EX, ADD x6,x5,x7 in ID
        drive(OPCODE_OP, 5'd5, 5'd7, 5'd5, LOAD_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("lu_add", E_BUBBLE);
        drive(OPCODE_OP, 5'd5, 5'd7, 5'd0, NO_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("lu_cleared", E_NONE);
        drive(OPCODE_BRANCH, 5'd1, 5'd9, 5'd9, LOAD_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("lu_branch_rs2", E_BUBBLE);
        drive(OPCODE_OPIMM, 5'd0, 5'd4, 5'd0, LOAD_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("lw_x0_addi", E_NONE);
        drive(OPCODE_LUI, 5'd5, 5'd5, 5'd5, LOAD_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("lui_no_src", E_NONE);

        for (int i = 0; i < 3; i++) begin
            drive(7'h00, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 1'b1, 1'b0, 1'b0);
            check_lit($sformatf("mem_wait_%0d", i), E_FREEZE);
        end
        drive(7'h00, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 1'b1, 1'b1, 1'b0);
        check_lit("mem_ready", E_NONE);
        idle(1'b0);
        check_lit("after_ready", E_NONE);
        check_state("after_ready_state", IDLE);
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (lu_stall_cnt_op !== 32'd2 || mem_stall_cnt_op !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_literal: got lu=%0d mem=%0d want lu=2 mem=3",
                     lu_stall_cnt_op, mem_stall_cnt_op);
        end
`endif

        // LW x3 in EX, SW rs2=x3 in ID, while MEM waits
        for (int i = 0; i < 2; i++) begin
            drive(OPCODE_STORE, 5'd1, 5'd3, 5'd3, LOAD_WRITEBACK, 1'b1, 1'b0, 1'b0);
            check_lit("both_wait", E_FREEZE);
        end
        drive(OPCODE_STORE, 5'd1, 5'd3, 5'd3, LOAD_WRITEBACK, 1'b1, 1'b1, 1'b0);
        check_lit("both_ready", E_NONE);
        drive(OPCODE_STORE, 5'd1, 5'd3, 5'd3, LOAD_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("both_bubble", E_BUBBLE);
        drive(OPCODE_STORE, 5'd1, 5'd3, 5'd0, NO_WRITEBACK, 1'b0, 1'b0, 1'b0);
        check_lit("both_clear", E_NONE);

        // Timeout: MAX_WAIT+1 freeze cycles, then sticky error
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            drive(7'h00, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 1'b1, 1'b0, 1'b0);
            check_lit($sformatf("timeout_wait_%0d", i), E_FREEZE);
        end
        for (int i = 0; i < 3; i++) begin
            drive(7'h00, 5'd0, 5'd0, 5'd0, NO_WRITEBACK, 1'b0, 1'b1, 1'b0);
            check_lit("error_sticky", E_ERROR);
            check_state("error_state", ERROR);
        end
        idle(1'b1);
        check_lit("error_during_reset", E_ERROR);
        idle(1'b0);
        check_lit("post_reset", E_NONE);
        check_state("post_reset_state", IDLE);

        // Randomized traffic with shifting memory-latency regimes
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 4;
                    1:       rdy_pct = 40;
                    default: rdy_pct = 85;
                endcase
            end
            idx = $urandom_range(0, 9);
            if (idx == 9) opc = 7'($urandom_range(0, 127));
            else          opc = opc_tab[idx];
            drive(opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), write_back_mux_selector'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) < rdy_pct),
                  1'($urandom_range(0, 99) == 0));
        end

        @(posedge clk);
        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
